escalonador_quantum: RTL and testbench
======================================

// Module: escalonador_quantum
// PURPOSE
//  Round-robin preemptive scheduler for the multiprogrammed processor. It counts
//  retired user instructions per time quantum and sequences the context switch:
//  save request -> PC capture -> next-ready pick -> PC restore.
//  It sits between Controle/BancoReg (save handshake), PC (forced load) and the
//  OS, which programs the ready mask and quantum.
// PARAMETERS
//  NUM_PROCS  8   number of program slots (power of 2); PID_W = clog2(NUM_PROCS)
//  QUANTUM    32  reset value of the quantum, in retired instructions
//  CNT_W      16  width of the quantum register and the instruction counter
// PORTS
//  clock        in   1          system clock (temporizador output)
//  reset        in   1          synchronous, active-high
//  enable       in   1          scheduler active (OS level signal)
//  instr_retire in   1          one-cycle pulse per executed user instruction
//  halt_prog    in   1          current program executed halt
//  ready_we     in   1          write ready mask
//  ready_data   in   NUM_PROCS  new ready mask, bit i = program i runnable
//  quantum_we   in   1          write quantum
//  quantum_data in   CNT_W      new quantum
//  pc_atual     in   32         PC of the running program (value to save)
//  save_ack     in   1          Controle/BancoReg finished the register save
//  prog_atual   out  PID_W      running program id
//  preempt_req  out  1          context switch in progress
//  save_req     out  1          request register save for prog_atual
//  pc_next      out  32         PC to load into PC
//  pc_load      out  1          one-cycle forced PC load strobe
//  all_done     out  1          no program ready; sticky until enable is low
// BEHAVIOUR
//  Reset: state=IDLE, prog_atual=0, ready mask=1 (only prog 0), quantum=QUANTUM,
//   counter=0, PC table all 0; all outputs 0 (pc_next=0).
//  States: IDLE, RUN, SAVE, PICK, RESTORE.
//  IDLE: when enable=1 and all_done=0 -> RUN, with counter=0. all_done clears when enable=0.
//  RUN: instr_retire increments the counter. A retire that makes counter==quantum,
//   or halt_prog=1 (wins when both occur in the same cycle) -> SAVE; record the halt flag.
//   enable=0 -> IDLE (no save).
//  SAVE: preempt_req=1, save_req=1, held until save_ack. On the save_ack cycle:
//   table[prog_atual]<=pc_atual; if the halt flag is set, clear ready[prog_atual].
//   Then -> PICK. Latency from trigger to save_req: 1 cycle.
//  PICK (1 cycle): next = first set bit of the registered mask, scanning
//   prog_atual+1 .. NUM_PROCS-1, wrap to 0 .. prog_atual (self is last).
//   No bit set -> IDLE, all_done=1, preempt_req=0.
//  RESTORE (1 cycle): prog_atual<=next, pc_next<=table[next], pc_load=1,
//   preempt_req=1. Then -> RUN with counter=0; preempt_req drops.
//   pc_next holds its value until the next RESTORE.
//  Total switch: save_ack + 2 cycles until pc_load.
//  instr_retire outside RUN is ignored. halt_prog outside RUN is ignored.
//  quantum_we: register updates next cycle; the new value applies from the next
//   counter compare. Value 0 is stored as 1.
//  ready_we: accepted in any state and visible the next cycle. If it collides
//   with a halt clear, the write applies first, then the halt clears its bit.
//  reset mid-switch: returns to IDLE immediately; save_req and pc_load drop in
//   the same edge.
// TESTING
//  T1 reset, mask=0b0011, quantum=4, enable; 4 retires -> save_req 1 cycle later;
//     save_ack with pc_atual=0x40 -> table[0]=0x40, pc_load with prog_atual=1.
//  T2 continue from T1: 4 retires on prog 1 -> switch back to prog 0,
//     pc_next=0x40, counter restarts at 0.
//  T3 mask=0b1001, prog 3 runs, halt_prog -> ready[3] cleared, prog 0 selected;
//     prog 0 halt -> all_done=1, IDLE, no pc_load.
//  T4 quantum_we=0 during RUN -> quantum reads 1; every retire causes a switch.
//  T5 save_req held 10 cycles without save_ack -> no state change and retires
//     ignored; reset asserted in SAVE -> IDLE, outputs 0 next cycle.
//  T6 ready_we clearing prog 2 in the cycle before PICK -> prog 2 skipped, next
//     set bit chosen with wrap-around.

Source files
------------

// File: rtl/escalonador_quantum.sv
// escalonador_quantum - round-robin preemptive scheduler.
// Counts retired user instructions per time quantum and sequences the context
// switch: save request -> PC capture -> next-ready pick -> PC restore.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   enable              scheduler active (OS level)
//   instr_retire        one-cycle pulse per retired user instruction
//   halt_prog           running program executed halt
//   ready_we/ready_data OS write of the ready mask (bit i = program i runnable)
//   quantum_we/_data    OS write of the quantum (0 is stored as 1)
//   pc_atual            PC of the running program, captured on save_ack
//   save_ack            register save finished
//   prog_atual          running program id
//   preempt_req         context switch in progress
//   save_req            request register save for prog_atual
//   pc_next, pc_load    PC to force-load and its one-cycle strobe
//   all_done            no program ready; sticky until enable is low
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | scheduler parked (disabled, or nothing left to run)
// RUN     | program prog_atual running, quantum counter active
// SAVE    | waiting for save_ack; PC of prog_atual captured on ack
// PICK    | choose next ready program after prog_atual (self last)
// RESTORE | pc_load strobe with the new prog_atual / pc_next
module escalonador_quantum #(
    parameter int NUM_PROCS = 8,
    parameter int QUANTUM   = 32,
    parameter int CNT_W     = 16,
    localparam int PID_W    = $clog2(NUM_PROCS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 instr_retire,
    input  logic                 halt_prog,
    input  logic                 ready_we,
    input  logic [NUM_PROCS-1:0] ready_data,
    input  logic                 quantum_we,
    input  logic [CNT_W-1:0]     quantum_data,
    input  logic [31:0]          pc_atual,
    input  logic                 save_ack,
    output logic [PID_W-1:0]     prog_atual,
    output logic                 preempt_req,
    output logic                 save_req,
    output logic [31:0]          pc_next,
    output logic                 pc_load,
    output logic                 all_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SAVE,
        ST_PICK,
        ST_RESTORE
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_PROCS-1:0] mask, mask_nxt;
    logic [CNT_W-1:0]     quantum;
    logic [CNT_W-1:0]     counter;
    logic [CNT_W:0]       cnt_inc;
    logic                 retire_hit;
    logic                 halt_flag;
    logic [31:0]          pc_table [NUM_PROCS];
    logic [PID_W-1:0]     scan_pid;
    logic [PID_W-1:0]     pick_pid;
    logic                 pick_found;

    // Compare with >= so a quantum lowered below the running count still
    // ends the slice on the next retire instead of waiting for wrap-around.
    assign cnt_inc    = {1'b0, counter} + {{CNT_W{1'b0}}, 1'b1};
    assign retire_hit = instr_retire && (cnt_inc >= {1'b0, quantum});

    // Rotating scan starting just after prog_atual; prog_atual itself is the
    // last candidate (k == NUM_PROCS wraps back to it).
    always_comb begin
        pick_found = 1'b0;
        pick_pid   = prog_atual;
        scan_pid   = prog_atual;
        for (int k = 1; k <= NUM_PROCS; k++) begin
            scan_pid = prog_atual + PID_W'(k);
            if (!pick_found && mask[scan_pid]) begin
                pick_found = 1'b1;
                pick_pid   = scan_pid;
            end
        end
    end

    // OS write lands first, a halt clear on the same cycle overrides its bit.
    always_comb begin
        mask_nxt = ready_we ? ready_data : mask;
        if (state == ST_SAVE && save_ack && halt_flag)
            mask_nxt[prog_atual] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        preempt_req = 1'b0;
        save_req    = 1'b0;
        pc_load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !all_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)                       state_nxt = ST_IDLE;
                else if (halt_prog || retire_hit)  state_nxt = ST_SAVE;
            end
            ST_SAVE: begin
                preempt_req = 1'b1;
                save_req    = 1'b1;
                if (save_ack) state_nxt = ST_PICK;
            end
            ST_PICK: begin
                preempt_req = 1'b1;
                state_nxt   = pick_found ? ST_RESTORE : ST_IDLE;
            end
            ST_RESTORE: begin
                preempt_req = 1'b1;
                pc_load     = 1'b1;
                state_nxt   = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask       <= NUM_PROCS'(1);
            quantum    <= CNT_W'(QUANTUM);
            counter    <= '0;
            prog_atual <= '0;
            pc_next    <= '0;
            halt_flag  <= 1'b0;
            all_done   <= 1'b0;
            for (int i = 0; i < NUM_PROCS; i++) pc_table[i] <= '0;
        end else begin
            mask <= mask_nxt;
            if (quantum_we)
                quantum <= (quantum_data == '0) ? CNT_W'(1) : quantum_data;
            if (!enable)
                all_done <= 1'b0;
            case (state)
                ST_IDLE: counter <= '0;
                ST_RUN: begin
                    if (state_nxt == ST_SAVE) halt_flag <= halt_prog;
                    else if (instr_retire)    counter   <= counter + 1'b1;
                end
                ST_SAVE: begin
                    if (save_ack) pc_table[prog_atual] <= pc_atual;
                end
                // prog_atual/pc_next move here so they are stable during the
                // RESTORE cycle that carries pc_load.
                ST_PICK: begin
                    if (pick_found) begin
                        prog_atual <= pick_pid;
                        pc_next    <= pc_table[pick_pid];
                    end else begin
                        all_done   <= 1'b1;
                    end
                end
                ST_RESTORE: counter <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_quantum.sv
module tb_escalonador_quantum;
    localparam int NP = 8;

    logic        clock = 1'b0;
    logic        reset, enable, instr_retire, halt_prog, ready_we, quantum_we, save_ack;
    logic [7:0]  ready_data;
    logic [15:0] quantum_data;
    logic [31:0] pc_atual;
    logic [2:0]  prog_atual;
    logic        preempt_req, save_req, pc_load, all_done;
    logic [31:0] pc_next;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0]  m_mask;
    int          m_quantum;
    int          m_prog;
    logic [31:0] m_table [NP];
    bit          m_all_done;

    escalonador_quantum dut (
        .clock(clock), .reset(reset), .enable(enable), .instr_retire(instr_retire),
        .halt_prog(halt_prog), .ready_we(ready_we), .ready_data(ready_data),
        .quantum_we(quantum_we), .quantum_data(quantum_data), .pc_atual(pc_atual),
        .save_ack(save_ack), .prog_atual(prog_atual), .preempt_req(preempt_req),
        .save_req(save_req), .pc_next(pc_next), .pc_load(pc_load), .all_done(all_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int ref_pick(input logic [7:0] mask, input int cur);
        for (int k = 1; k <= NP; k++) begin
            int idx = (cur + k) % NP;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mask = 8'b0000_0001;
        m_quantum = 32;
        m_prog = 0;
        m_all_done = 0;
        for (int i = 0; i < NP; i++) m_table[i] = '0;
    endtask

    task automatic write_cfg(input bit wm, input logic [7:0] md, input bit wq, input logic [15:0] qd);
        ready_we = wm; ready_data = md; quantum_we = wq; quantum_data = qd;
        tick();
        ready_we = 0; quantum_we = 0;
        if (wm) m_mask = md;
        if (wq) m_quantum = (qd == 0) ? 1 : int'(qd);
    endtask

    task automatic trigger_quantum(input string tag);
        for (int i = 0; i < m_quantum; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            instr_retire = 1; tick(); instr_retire = 0;
            n_checks++;
            if (i < m_quantum - 1) begin
                if (save_req !== 1'b0) begin n_fail++; $display("FAIL %s_early_save retire %0d: got %b want 0", tag, i + 1, save_req); end
            end else begin
                if (save_req !== 1'b1 || preempt_req !== 1'b1) begin n_fail++; $display("FAIL %s_quantum_save: save_req=%b preempt_req=%b want 1/1", tag, save_req, preempt_req); end
            end
        end
    endtask

    task automatic trigger_halt(input string tag);
        int pre = $urandom_range(0, m_quantum - 1);
        for (int i = 0; i < pre; i++) begin
            instr_retire = 1; tick(); instr_retire = 0;
        end
        halt_prog = 1; instr_retire = 1'($urandom_range(0, 1));
        tick();
        halt_prog = 0; instr_retire = 0;
        n_checks++;
        if (save_req !== 1'b1) begin n_fail++; $display("FAIL %s_halt_save: got %b want 1", tag, save_req); end
    endtask

    task automatic finish_switch(input logic [31:0] pc, input bit halted, input bit we,
                                 input logic [7:0] wd, input string tag);
        int nxt;
        pc_atual = pc; save_ack = 1; ready_we = we; ready_data = wd;
        tick();
        save_ack = 0; ready_we = 0;
        n_checks++;
        if (save_req !== 1'b0 || pc_load !== 1'b0) begin n_fail++; $display("FAIL %s_pick_outputs: save_req=%b pc_load=%b want 0/0", tag, save_req, pc_load); end
        m_table[m_prog] = pc;
        if (we) m_mask = wd;
        if (halted) m_mask[m_prog] = 1'b0;
        nxt = ref_pick(m_mask, m_prog);
        tick();
        if (nxt >= 0) begin
            n_checks++;
            if (pc_load !== 1'b1 || prog_atual !== 3'(nxt) || pc_next !== m_table[nxt]) begin
                n_fail++;
                $display("FAIL %s_restore: pc_load=%b prog=%0d pc_next=%h want 1 prog=%0d pc_next=%h", tag, pc_load, prog_atual, pc_next, nxt, m_table[nxt]);
            end
            m_prog = nxt;
            tick();
            n_checks++;
            if (pc_load !== 1'b0 || preempt_req !== 1'b0) begin n_fail++; $display("FAIL %s_back_to_run: pc_load=%b preempt_req=%b want 0/0", tag, pc_load, preempt_req); end
        end else begin
            n_checks++;
            if (all_done !== 1'b1 || pc_load !== 1'b0 || preempt_req !== 1'b0 || prog_atual !== 3'(m_prog)) begin
                n_fail++;
                $display("FAIL %s_all_done: all_done=%b pc_load=%b preempt=%b prog=%0d want 1/0/0 prog=%0d", tag, all_done, pc_load, preempt_req, prog_atual, m_prog);
            end
            m_all_done = 1;
        end
    endtask

    task automatic restart_if_done(input string tag);
        if (m_all_done) begin
            enable = 0; tick();
            n_checks++;
            if (all_done !== 1'b0) begin n_fail++; $display("FAIL %s_all_done_clear: got %b want 0", tag, all_done); end
            m_all_done = 0;
            enable = 1;
            write_cfg(1, 8'($urandom_range(1, 255)), 0, 0);
        end
    endtask

    task automatic test_reset();
        enable = 0; instr_retire = 0; halt_prog = 0; ready_we = 0; ready_data = 0;
        quantum_we = 0; quantum_data = 0; pc_atual = 0; save_ack = 0;
        reset = 1; tick(); tick(); reset = 0;
        model_reset();
        n_checks++;
        if (prog_atual !== 3'd0 || preempt_req !== 1'b0 || save_req !== 1'b0 ||
            pc_next !== 32'd0 || pc_load !== 1'b0 || all_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: prog=%0d preempt=%b save=%b pc_next=%h pc_load=%b all_done=%b want all 0",
                     prog_atual, preempt_req, save_req, pc_next, pc_load, all_done);
        end
    endtask

    task automatic test_t1_first_switch();
        enable = 1;
        write_cfg(1, 8'b0000_0011, 1, 16'd4);
        trigger_quantum("t1");
        finish_switch(32'h40, 0, 0, 8'h00, "t1");
    endtask

    task automatic test_t2_switch_back();
        trigger_quantum("t2");
        finish_switch($urandom, 0, 0, 8'h00, "t2");
    endtask

    task automatic test_t3_halt();
        write_cfg(1, 8'b0000_1001, 0, 0);
        trigger_quantum("t3a");
        finish_switch($urandom, 0, 0, 8'h00, "t3a");
        trigger_halt("t3b");
        finish_switch($urandom, 1, 0, 8'h00, "t3b");
        trigger_halt("t3c");
        finish_switch($urandom, 1, 0, 8'h00, "t3c");
        instr_retire = 1; tick(); instr_retire = 0; tick();
        n_checks++;
        if (save_req !== 1'b0 || all_done !== 1'b1) begin n_fail++; $display("FAIL t3_idle_sticky: save_req=%b all_done=%b want 0/1", save_req, all_done); end
        restart_if_done("t3");
    endtask

    task automatic test_t4_quantum_zero();
        write_cfg(0, 8'h00, 1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            trigger_quantum("t4");
            finish_switch($urandom, 0, 0, 8'h00, "t4");
            restart_if_done("t4");
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            bit halted;
            restart_if_done("rnd");
            if ($urandom_range(0, 3) == 0) write_cfg(0, 8'h00, 1, 16'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) write_cfg(1, 8'($urandom_range(0, 255)), 0, 0);
            halted = ($urandom_range(0, 2) == 0);
            if (halted) trigger_halt("rnd");
            else        trigger_quantum("rnd");
            finish_switch($urandom, halted, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), "rnd");
        end
        restart_if_done("rnd");
    endtask

    task automatic test_disable_restart();
        write_cfg(0, 8'h00, 1, 16'd3);
        instr_retire = 1; tick(); tick(); instr_retire = 0;
        enable = 0; tick();
        instr_retire = 1; tick(); instr_retire = 0;
        n_checks++;
        if (save_req !== 1'b0) begin n_fail++; $display("FAIL disable_no_save: got %b want 0", save_req); end
        enable = 1; tick();
        trigger_quantum("dis");
        finish_switch($urandom, 0, 0, 8'h00, "dis");
        restart_if_done("dis");
    endtask

    task automatic test_t5_hold_and_reset();
        write_cfg(0, 8'h00, 1, 16'd3);
        trigger_quantum("t5");
        for (int i = 0; i < 10; i++) begin
            instr_retire = 1'($urandom_range(0, 1)); halt_prog = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (save_req !== 1'b1 || pc_load !== 1'b0) begin n_fail++; $display("FAIL t5_hold cycle %0d: save_req=%b pc_load=%b want 1/0", i, save_req, pc_load); end
        end
        instr_retire = 0; halt_prog = 0; enable = 0;
        reset = 1; tick(); reset = 0;
        model_reset();
        n_checks++;
        if (save_req !== 1'b0 || pc_load !== 1'b0 || preempt_req !== 1'b0 ||
            prog_atual !== 3'd0 || pc_next !== 32'd0 || all_done !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_reset_in_save: save=%b pc_load=%b preempt=%b prog=%0d pc_next=%h all_done=%b want all 0",
                     save_req, pc_load, preempt_req, prog_atual, pc_next, all_done);
        end
    endtask

    task automatic test_t6_late_mask_write();
        enable = 1;
        write_cfg(1, 8'b0000_0111, 1, 16'd1);
        trigger_quantum("t6a");
        finish_switch($urandom, 0, 0, 8'h00, "t6a");
        trigger_quantum("t6b");
        finish_switch($urandom, 0, 1, 8'b0000_0011, "t6b");
        trigger_halt("t6c");
        finish_switch($urandom, 1, 1, 8'b0000_0011, "t6c");
    endtask

    initial begin
        test_reset();
        test_t1_first_switch();
        test_t2_switch_back();
        test_t3_halt();
        test_t4_quantum_zero();
        test_random();
        test_disable_restart();
        test_t5_hold_and_reset();
        test_t6_late_mask_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
